// File: rtl/conv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : conv_pkg
// Purpose  : Shared types and helpers for the convolution tap cascade:
//            control FSM state encoding, accumulator width and
//            identity-coefficient values.
// Revision : 1.0 - initial release
// ============================================================================
package conv_pkg;

    // Control FSM states: normal streaming, pipeline drain, bank swap
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        SWAP  = 2'd2
    } state_t;

    // Accumulator width wide enough that a full cascade sum cannot overflow
    function automatic int acc_width(input int data_w, input int coef_w, input int n_taps);
        return data_w + coef_w + $clog2(n_taps) + 1;
    endfunction

    // Identity filter: unity gain (1.0 in fixed point) on the centre tap only
    function automatic int ident_coef(input int k, input int n_taps, input int shift);
        return (k == n_taps / 2) ? (1 << shift) : 0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/conv_mac_stage.sv
`default_nettype none
// ============================================================================
// Module   : conv_mac_stage
// Purpose  : One registered systolic multiply-accumulate stage. Adds the
//            signed product of a zero-extended pixel and a signed
//            coefficient to the incoming cascade sum.
// Revision : 1.0 - initial release
// ============================================================================
module conv_mac_stage #(
    parameter int DATA_W = 8,
    parameter int COEF_W = 8,
    parameter int ACC_W  = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] x,
    input  logic [COEF_W-1:0] coef,
    input  logic [ACC_W-1:0]  sum_in,
    input  logic              valid_in,
    output logic [ACC_W-1:0]  sum_out,
    output logic              valid_out
);

    // Product width holds pixel (plus sign bit) times coefficient exactly
    localparam int c_prod_w = DATA_W + COEF_W + 1;

    logic signed [c_prod_w-1:0] w_xs;
    logic signed [c_prod_w-1:0] w_cs;
    logic signed [c_prod_w-1:0] w_prod;
    logic        [ACC_W-1:0]    r_sum;
    logic                       r_valid;

    // Pixel is unsigned, so it enters the signed multiply zero-extended
    assign w_xs   = c_prod_w'({1'b0, x});
    assign w_cs   = c_prod_w'($signed(coef));
    assign w_prod = w_xs * w_cs;

    // Register the partial sum and the valid bit travelling with it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sum   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_sum   <= sum_in + ACC_W'(w_prod);
            r_valid <= valid_in;
        end
    end

    assign sum_out   = r_sum;
    assign valid_out = r_valid;

endmodule
`default_nettype wire

// File: rtl/conv_tap_cascade.sv
`default_nettype none
// ============================================================================
// Module   : conv_tap_cascade
// Purpose  : Systolic N-tap convolution MAC cascade with double-buffered
//            runtime coefficients (drain-and-swap commit), rounding,
//            right shift and saturation to one output pixel per cycle.
//            Bypass mode passes the centre tap through at equal latency.
// Revision : 1.0 - initial release
// ============================================================================
module conv_tap_cascade
    import conv_pkg::*;
#(
    parameter int N_TAPS = 5,
    parameter int DATA_W = 8,
    parameter int COEF_W = 8,
    parameter int SHIFT  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_TAPS*DATA_W-1:0]   px_in,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       bypass,
    input  logic                       coef_we,
    input  logic [$clog2(N_TAPS)-1:0]  coef_addr,
    input  logic [COEF_W-1:0]          coef_wdata,
    input  logic                       coef_commit,
    output logic [DATA_W-1:0]          p_out,
    output logic                       out_valid
);

    localparam int c_acc_w  = acc_width(DATA_W, COEF_W, N_TAPS);
    localparam int c_addr_w = $clog2(N_TAPS);
    localparam int c_ctr    = N_TAPS / 2;
    // Half an output LSB, added before the shift for round-half-up
    localparam logic signed [c_acc_w-1:0] c_rnd  = c_acc_w'((1 << SHIFT) >> 1);
    localparam logic signed [c_acc_w-1:0] c_pmax = c_acc_w'((1 << DATA_W) - 1);

    state_t                       r_state;
    logic                         r_in_ready;
    logic                         w_accept;
    logic                         w_in_flight;

    logic [N_TAPS*DATA_W-1:0]     r_px;
    logic                         r_in_vld;
    logic                         r_in_byp;

    logic [COEF_W-1:0]            r_active [N_TAPS];
    logic [COEF_W-1:0]            r_shadow [N_TAPS];

    logic [DATA_W-1:0]            w_x   [N_TAPS];
    logic signed [c_acc_w-1:0]    w_sum [N_TAPS+1];
    logic                         w_vld [N_TAPS+1];

    logic                         r_byp [N_TAPS];
    logic [DATA_W-1:0]            r_ctr [N_TAPS];

    logic signed [c_acc_w-1:0]    r_rnd;
    logic                         r_rnd_vld;
    logic                         r_rnd_byp;
    logic [DATA_W-1:0]            r_rnd_ctr;
    logic [DATA_W-1:0]            w_clamp;

    logic [DATA_W-1:0]            r_p_out;
    logic                         r_out_valid;

    assign w_accept = in_valid & r_in_ready;

    // Input register: captures an accepted sample with its bypass flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_in_vld <= 1'b0;
            r_in_byp <= 1'b0;
            r_px     <= '0;
        end else begin
            r_in_vld <= w_accept;
            if (w_accept) begin
                r_px     <= px_in;
                r_in_byp <= bypass;
            end
        end
    end

    // Bypass flag and centre pixel ride alongside the MAC stages
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < N_TAPS; k++) begin
                r_byp[k] <= 1'b0;
                r_ctr[k] <= '0;
            end
        end else begin
            r_byp[0] <= r_in_byp;
            r_ctr[0] <= r_px[c_ctr*DATA_W +: DATA_W];
            for (int k = 1; k < N_TAPS; k++) begin
                r_byp[k] <= r_byp[k-1];
                r_ctr[k] <= r_ctr[k-1];
            end
        end
    end

    assign w_sum[0] = '0;
    assign w_vld[0] = r_in_vld;

    // Tap k is delayed k cycles so it meets its sample's partial sum at stage k
    for (genvar k = 0; k < N_TAPS; k++) begin : g_tap
        if (k == 0) begin : g_direct
            assign w_x[k] = r_px[DATA_W-1:0];
        end else begin : g_delay
            logic [DATA_W-1:0] r_dl [k];

            // Per-tap alignment delay line
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int j = 0; j < k; j++) begin
                        r_dl[j] <= '0;
                    end
                end else begin
                    r_dl[0] <= r_px[k*DATA_W +: DATA_W];
                    for (int j = 1; j < k; j++) begin
                        r_dl[j] <= r_dl[j-1];
                    end
                end
            end

            assign w_x[k] = r_dl[k-1];
        end

        conv_mac_stage #(
            .DATA_W (DATA_W),
            .COEF_W (COEF_W),
            .ACC_W  (c_acc_w)
        ) u_mac (
            .clk       (clk),
            .rst       (rst),
            .x         (w_x[k]),
            .coef      (r_active[k]),
            .sum_in    (w_sum[k]),
            .valid_in  (w_vld[k]),
            .sum_out   (w_sum[k+1]),
            .valid_out (w_vld[k+1])
        );
    end

    // Any sample still depending on the active bank blocks the swap
    always_comb begin
        w_in_flight = r_in_vld;
        for (int k = 1; k <= N_TAPS; k++) begin
            w_in_flight = w_in_flight | w_vld[k];
        end
    end

    // Commit FSM: stop intake, wait for the MAC pipe to empty, then swap banks
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= RUN;
            r_in_ready <= 1'b1;
        end else begin
            case (r_state)
                RUN: begin
                    if (coef_commit) begin
                        r_state    <= DRAIN;
                        r_in_ready <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (!w_in_flight) begin
                        r_state <= SWAP;
                    end
                end
                SWAP: begin
                    r_state    <= RUN;
                    r_in_ready <= 1'b1;
                end
                default: begin
                    r_state    <= RUN;
                    r_in_ready <= 1'b1;
                end
            endcase
        end
    end

    // Coefficient banks: writes go to shadow only; all taps copy at once in SWAP
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < N_TAPS; k++) begin
                r_active[k] <= COEF_W'(ident_coef(k, N_TAPS, SHIFT));
                r_shadow[k] <= COEF_W'(ident_coef(k, N_TAPS, SHIFT));
            end
        end else begin
            for (int k = 0; k < N_TAPS; k++) begin
                if (coef_we && (coef_addr == c_addr_w'(k))) begin
                    r_shadow[k] <= coef_wdata;
                end
                if (r_state == SWAP) begin
                    r_active[k] <= r_shadow[k];
                end
            end
        end
    end

    // Round and arithmetic-shift the finished cascade sum
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rnd     <= '0;
            r_rnd_vld <= 1'b0;
            r_rnd_byp <= 1'b0;
            r_rnd_ctr <= '0;
        end else begin
            r_rnd_vld <= w_vld[N_TAPS];
            if (w_vld[N_TAPS]) begin
                r_rnd     <= (w_sum[N_TAPS] + c_rnd) >>> SHIFT;
                r_rnd_byp <= r_byp[N_TAPS-1];
                r_rnd_ctr <= r_ctr[N_TAPS-1];
            end
        end
    end

    // Saturate the shifted result into the unsigned pixel range
    always_comb begin
        w_clamp = r_rnd[DATA_W-1:0];
        if (r_rnd[c_acc_w-1]) begin
            w_clamp = '0;
        end else if (r_rnd > c_pmax) begin
            w_clamp = '1;
        end
    end

    // Output register: holds the last pixel between valid strobes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_p_out     <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= r_rnd_vld;
            if (r_rnd_vld) begin
                r_p_out <= r_rnd_byp ? r_rnd_ctr : w_clamp;
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign p_out     = r_p_out;
    assign out_valid = r_out_valid;

endmodule
`default_nettype wire
